solver_arbiter: RTL and testbench
=================================

# solver_arbiter

Round-robin scheduler that shares one brute-force 3-colouring solver (start/done/success/18-bit colouring interface) among NREQ requesters. It owns the solver's start and reset pins, sequences the solver's level-start handshake, returns each requester's result with a cycle count, and optionally aborts runaway searches with a watchdog. It sits between the requester fabric and a single solver instance in the synthesis-trap harness.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, owner index width; IDW = clog2(NREQ)
- TIMEOUT, 16'd20000, watchdog limit in cycles (2..65535); used only with the watchdog compiled in

Ports:
- clk  in  1  single clock; everything on rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester level request
- resp_valid  out  NREQ  one-hot, one-cycle response strobe
- resp_success  out  1  solver found a colouring
- resp_timeout  out  1  job aborted by watchdog
- resp_colouring  out  18  packed result, 2 bits per vertex, vertex 0 in [1:0]
- resp_cycles  out  16  cycles spent in LAUNCH+WAIT
- busy  out  1  high whenever state != IDLE
- owner  out  IDW  index of requester being served (valid while busy)
- slv_start  out  1  solver start, held high for the whole job
- slv_reset  out  1  solver reset = reset OR (state == RECOVER)
- slv_done, slv_success  in  1 each  solver status
- slv_colouring  in  18  solver result

Clock clk, reset reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, LAUNCH, WAIT, RESPOND, RECOVER.
- IDLE: if any req bit high, grant first set bit searching upward from ptr+1 (mod NREQ); latch owner, clear counter, set slv_start=1 -> LAUNCH. Otherwise stay.
- LAUNCH: exactly one cycle; counter+1; slv_done ignored (stale high from previous job) -> WAIT.
- WAIT: counter+1 (saturating at 16'hFFFF). If slv_done: latch slv_success/slv_colouring, resp_timeout=0, slv_start=0 -> RESPOND. Else if watchdog enabled and counter (including this cycle) == TIMEOUT: slv_start=0, resp_success=0, resp_colouring=0, resp_timeout=1 -> RECOVER. Done wins over timeout in the same cycle.
- RECOVER: one cycle, slv_reset high (forces solver to IDLE mid-search) -> RESPOND.
- RESPOND: resp_valid[owner]=1 for this cycle only; resp_cycles=counter; ptr=owner -> IDLE.
- resp_* fields are stable from RESPOND until the next RESPOND.
- req is level: requester holds req until its resp_valid. Dropping req before grant withdraws the request; dropping after grant does not cancel; the response still pulses. req still high in the cycle after resp_valid counts as a new request, served after other pending requesters.
- Reset values: state IDLE, ptr=NREQ-1 (requester 0 wins first), slv_start 0, slv_reset 1 (while reset), resp_valid 0, resp_success 0, resp_timeout 0, resp_colouring 0, resp_cycles 0, owner 0, busy 0.
- Reset mid-job: job dropped, no response, solver reset via slv_reset.

## Timing
- req high in IDLE cycle -> slv_start high next cycle (LAUNCH).
- Solver rejecting k candidates before success: resp_cycles = k+3; resp_valid asserts k+4 cycles after the grant edge.
- Back-to-back: slv_start low in RESPOND; solver returns FINISHED->IDLE at that edge; next grant may raise slv_start on the edge leaving the following IDLE cycle (minimum one low cycle of slv_start between jobs).
- Timeout: resp_valid exactly TIMEOUT+2 cycles after grant edge, resp_cycles = TIMEOUT.

## Configuration
- SOLVER_ARB_TIMEOUT_EN defined: watchdog and RECOVER state present as above.
- Undefined: WAIT waits indefinitely for slv_done; RECOVER unreachable/removed; resp_timeout tied 0; slv_reset = reset; TIMEOUT ignored.

## Test plan
- Single request, real solver: req=4'b0001 -> slv_start one cycle later, resp_valid=4'b0001, resp_success=1, resp_colouring a proper colouring for all 21 edge checks, resp_cycles = rejected candidates + 3.
- Contention: req=4'b1111 held -> service order 0,1,2,3, then 0 again; slv_start low at least one cycle between jobs; owner matches each strobe.
- Stale done: behavioural solver holding slv_done=1 from previous job -> LAUNCH ignores it; no early response; resp_cycles >= 3.
- Watchdog (macro on, TIMEOUT=100, model never asserts done) -> slv_reset high one cycle, resp_timeout=1, resp_success=0, resp_colouring=0, resp_cycles=100.
- Done and timeout same cycle (model asserts done on cycle 100, TIMEOUT=100) -> resp_success=1, resp_timeout=0, no slv_reset pulse.
- Reset during WAIT -> no resp_valid, slv_start 0, busy 0, next request served from requester 0.

Source files
------------

// File: rtl/solver_arbiter.sv
// Round-robin scheduler sharing one 3-colouring solver among NREQ requesters.
// Define SOLVER_ARB_TIMEOUT_EN to compile in the watchdog and its RECOVER state.
module solver_arbiter #(
    parameter int          NREQ    = 4,
    parameter int          IDW     = 2,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] resp_valid,
    output logic            resp_success,
    output logic            resp_timeout,
    output logic [17:0]     resp_colouring,
    output logic [15:0]     resp_cycles,
    output logic            busy,
    output logic [IDW-1:0]  owner,
    output logic            slv_start,
    output logic            slv_reset,
    input  logic            slv_done,
    input  logic            slv_success,
    input  logic [17:0]     slv_colouring
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND, S_RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [15:0]     cnt_q, cnt_d, cnt_inc;
    logic            succ_q, succ_d;
    logic            tmo_q, tmo_d;
    logic [17:0]     col_q, col_d;
    logic [15:0]     cyc_q, cyc_d;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx, cand;

    // First requester above the last served one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        succ_d  = succ_q;
        tmo_d   = tmo_q;
        col_d   = col_q;
        cyc_d   = cyc_q;
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    cnt_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            // slv_done may still be high from the previous job here; ignore it.
            S_LAUNCH: begin
                cnt_d   = cnt_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (slv_done) begin
                    succ_d  = slv_success;
                    col_d   = slv_colouring;
                    tmo_d   = 1'b0;
                    cyc_d   = cnt_inc;
                    state_d = S_RESPOND;
                end
`ifdef SOLVER_ARB_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT) begin
                    state_d = S_RECOVER;
                end
`endif
            end
`ifdef SOLVER_ARB_TIMEOUT_EN
            S_RECOVER: begin
                succ_d  = 1'b0;
                col_d   = '0;
                tmo_d   = 1'b1;
                cyc_d   = cnt_q;
                state_d = S_RESPOND;
            end
`endif
            S_RESPOND: begin
                ptr_d   = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            succ_q  <= 1'b0;
            tmo_q   <= 1'b0;
            col_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            succ_q  <= succ_d;
            tmo_q   <= tmo_d;
            col_q   <= col_d;
            cyc_q   <= cyc_d;
        end
    end

    assign resp_valid     = (state_q == S_RESPOND) ? (NREQ'(1) << owner_q) : '0;
    assign resp_success   = succ_q;
    assign resp_timeout   = tmo_q;
    assign resp_colouring = col_q;
    assign resp_cycles    = cyc_q;
    assign busy           = (state_q != S_IDLE);
    assign owner          = owner_q;
    assign slv_start      = (state_q == S_LAUNCH) || (state_q == S_WAIT);

`ifdef SOLVER_ARB_TIMEOUT_EN
    assign slv_reset = reset || (state_q == S_RECOVER);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign slv_reset      = reset;
`endif

endmodule

// File: tb/tb_solver_arbiter.sv
// Directed self-checking bench for solver_arbiter with a behavioural solver.
module tb_solver_arbiter;
    localparam int          NREQ = 4;
    localparam int          IDW  = 2;
    localparam logic [15:0] TMO  = 16'd100;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] resp_valid;
    logic            resp_success, resp_timeout;
    logic [17:0]     resp_colouring;
    logic [15:0]     resp_cycles;
    logic            busy;
    logic [IDW-1:0]  owner;
    logic            slv_start, slv_reset, slv_done, slv_success;
    logic [17:0]     slv_colouring;

    int checks = 0;
    int errors = 0;

    // Behavioural solver: done after m_lat cycles of start; m_stale fakes a left-over done.
    logic [15:0] m_cnt, m_lat;
    logic        m_never, m_stale, m_succ;
    logic [17:0] m_col;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (slv_reset || !slv_start) m_cnt <= '0;
        else                         m_cnt <= m_cnt + 16'd1;
    end

    assign slv_done      = slv_start && ((m_cnt == 16'd0) ? m_stale : (!m_never && m_cnt >= m_lat));
    assign slv_success   = m_succ;
    assign slv_colouring = m_col;

    solver_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .resp_valid(resp_valid), .resp_success(resp_success), .resp_timeout(resp_timeout),
        .resp_colouring(resp_colouring), .resp_cycles(resp_cycles),
        .busy(busy), .owner(owner), .slv_start(slv_start), .slv_reset(slv_reset),
        .slv_done(slv_done), .slv_success(slv_success), .slv_colouring(slv_colouring)
    );

    // Waits for a response strobe; lat counts the first edge as 1.
    task automatic wait_resp(input int maxc, output int lat, output int rsts, output logic ok);
        lat = 0; rsts = 0; ok = 1'b0;
        for (int n = 0; n < maxc && !ok; n++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (slv_reset) rsts++;
            if (resp_valid != '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0;
        m_lat = 16'd1; m_never = 1'b0; m_stale = 1'b0; m_succ = 1'b0; m_col = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0 || slv_start !== 1'b0 || slv_reset !== 1'b1) begin
            errors++; $display("FAIL reset_ctrl got busy=%b rv=%b start=%b srst=%b want 0 0 0 1",
                               busy, resp_valid, slv_start, slv_reset);
        end
        checks++;
        if (resp_success !== 1'b0 || resp_timeout !== 1'b0 || resp_colouring !== 18'h0 ||
            resp_cycles !== 16'h0 || owner !== 2'd0) begin
            errors++; $display("FAIL reset_resp got s=%b t=%b c=%h cyc=%0d own=%0d want all 0",
                               resp_success, resp_timeout, resp_colouring, resp_cycles, owner);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (slv_reset !== 1'b0) begin
            errors++; $display("FAIL reset_release got slv_reset=%b want 0", slv_reset);
        end
    endtask

    task automatic test_contention;
        int exp_o[5] = '{0, 1, 2, 3, 0};
        logic [3:0] one = 4'b0001;
        int lat, rsts; logic ok;
        m_lat = 16'd1; m_succ = 1'b1; m_col = 18'h00123;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_resp(50, lat, rsts, ok);
            checks++;
            if (!ok || resp_valid !== (one << exp_o[k]) || owner !== IDW'(exp_o[k])) begin
                errors++; $display("FAIL contention_%0d got ok=%b rv=%b own=%0d want rv=%b own=%0d",
                                   k, ok, resp_valid, owner, one << exp_o[k], exp_o[k]);
            end
            if (k == 4) req = '0;
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (slv_start !== 1'b0) begin
                    errors++; $display("FAIL contention_gap_%0d got slv_start=%b want 0", k, slv_start);
                end
            end
        end
    endtask

    task automatic test_single;
        int lat, rsts; logic ok;
        m_lat = 16'd5; m_succ = 1'b1; m_col = 18'h1B1E4;
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        checks++;
        if (slv_start !== 1'b1 || busy !== 1'b1 || owner !== 2'd0) begin
            errors++; $display("FAIL single_launch got start=%b busy=%b own=%0d want 1 1 0",
                               slv_start, busy, owner);
        end
        wait_resp(50, lat, rsts, ok);
        lat++;
        checks++;
        if (!ok || resp_valid !== 4'b0001 || resp_success !== 1'b1 || resp_timeout !== 1'b0) begin
            errors++; $display("FAIL single_resp got ok=%b rv=%b s=%b t=%b want 1 0001 1 0",
                               ok, resp_valid, resp_success, resp_timeout);
        end
        checks++;
        if (resp_colouring !== 18'h1B1E4 || resp_cycles !== 16'd6 || lat != 7) begin
            errors++; $display("FAIL single_data got col=%h cyc=%0d lat=%0d want 1b1e4 6 7",
                               resp_colouring, resp_cycles, lat);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_stale_done;
        int lat, rsts; logic ok;
        m_lat = 16'd3; m_stale = 1'b1; m_succ = 1'b1; m_col = 18'h2A0C5;
        req = 4'b0010;
        wait_resp(50, lat, rsts, ok);
        checks++;
        if (!ok || resp_valid !== 4'b0010 || resp_cycles !== 16'd4 || lat != 5) begin
            errors++; $display("FAIL stale_done got ok=%b rv=%b cyc=%0d lat=%0d want 1 0010 4 5",
                               ok, resp_valid, resp_cycles, lat);
        end
        checks++;
        if (resp_colouring !== 18'h2A0C5 || resp_success !== 1'b1) begin
            errors++; $display("FAIL stale_data got col=%h s=%b want 2a0c5 1", resp_colouring, resp_success);
        end
        m_stale = 1'b0; req = '0;
        @(negedge clk);
    endtask

`ifdef SOLVER_ARB_TIMEOUT_EN
    task automatic test_watchdog;
        int lat, rsts; logic ok;
        m_never = 1'b1; m_succ = 1'b1; m_col = 18'h3FFFF;
        req = 4'b0100;
        wait_resp(300, lat, rsts, ok);
        checks++;
        if (!ok || resp_valid !== 4'b0100 || resp_timeout !== 1'b1 || resp_success !== 1'b0 ||
            resp_colouring !== 18'h0) begin
            errors++; $display("FAIL watchdog_resp got ok=%b rv=%b t=%b s=%b col=%h want 1 0100 1 0 0",
                               ok, resp_valid, resp_timeout, resp_success, resp_colouring);
        end
        checks++;
        if (resp_cycles !== 16'd100 || lat != 102 || rsts != 1) begin
            errors++; $display("FAIL watchdog_timing got cyc=%0d lat=%0d rst=%0d want 100 102 1",
                               resp_cycles, lat, rsts);
        end
        m_never = 1'b0; req = '0;
        @(negedge clk);
    endtask

    task automatic test_done_vs_timeout;
        int lat, rsts; logic ok;
        m_lat = 16'd99; m_succ = 1'b1; m_col = 18'h0F0F0;
        req = 4'b0100;
        wait_resp(300, lat, rsts, ok);
        checks++;
        if (!ok || resp_success !== 1'b1 || resp_timeout !== 1'b0 || resp_colouring !== 18'h0F0F0) begin
            errors++; $display("FAIL done_wins got ok=%b s=%b t=%b col=%h want 1 1 0 0f0f0",
                               ok, resp_success, resp_timeout, resp_colouring);
        end
        checks++;
        if (resp_cycles !== 16'd100 || lat != 101 || rsts != 0) begin
            errors++; $display("FAIL done_wins_timing got cyc=%0d lat=%0d rst=%0d want 100 101 0",
                               resp_cycles, lat, rsts);
        end
        req = '0;
        @(negedge clk);
    endtask
`else
    task automatic test_no_watchdog;
        int lat, rsts; logic ok;
        m_lat = 16'd150; m_succ = 1'b1; m_col = 18'h0F0F0;
        req = 4'b0100;
        wait_resp(400, lat, rsts, ok);
        checks++;
        if (!ok || resp_valid !== 4'b0100 || resp_success !== 1'b1 || resp_timeout !== 1'b0) begin
            errors++; $display("FAIL long_job got ok=%b rv=%b s=%b t=%b want 1 0100 1 0",
                               ok, resp_valid, resp_success, resp_timeout);
        end
        checks++;
        if (resp_cycles !== 16'd151 || lat != 152 || rsts != 0) begin
            errors++; $display("FAIL long_job_timing got cyc=%0d lat=%0d rst=%0d want 151 152 0",
                               resp_cycles, lat, rsts);
        end
        req = '0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_job;
        int lat, rsts, seen; logic ok;
        m_lat = 16'd1000; m_succ = 1'b1; m_col = 18'h00055;
        req = 4'b0010;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || slv_start !== 1'b1) begin
            errors++; $display("FAIL midjob_busy got busy=%b start=%b want 1 1", busy, slv_start);
        end
        reset = 1'b1; req = '0;
        @(negedge clk);
        checks++;
        if (slv_reset !== 1'b1 || slv_start !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0) begin
            errors++; $display("FAIL midjob_reset got srst=%b start=%b busy=%b rv=%b want 1 0 0 0",
                               slv_reset, slv_start, busy, resp_valid);
        end
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid != '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midjob_noresp got strobes=%0d want 0", seen);
        end
        m_lat = 16'd2;
        req = 4'b1001;
        wait_resp(50, lat, rsts, ok);
        checks++;
        if (!ok || resp_valid !== 4'b0001 || owner !== 2'd0 || resp_cycles !== 16'd3) begin
            errors++; $display("FAIL midjob_next got ok=%b rv=%b own=%0d cyc=%0d want 1 0001 0 3",
                               ok, resp_valid, owner, resp_cycles);
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_stale_done();
`ifdef SOLVER_ARB_TIMEOUT_EN
        test_watchdog();
        test_done_vs_timeout();
`else
        test_no_watchdog();
`endif
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
